// File: rtl/ac97_deframer_ms.sv
// rtl/ac97_deframer_ms.sv - AC'97 SDATA_IN frame deframer with shadow/publish slot capture
//
// Purpose: counts accepted link bits relative to SYNC rising edges, captures
// the tag bits and the first SLOT_BITS bits of slots 1..NSLOTS into shadow
// registers, and publishes the shadows to the outputs in one step when the
// last decoded bit of the frame has been accepted.
//
// Ports:
//   sys_clk, sys_rst     clock, synchronous active-high reset
//   up_stb, up_ack       bit strobe in, acknowledge out (mirrors en)
//   up_sync, up_data     AC-link SYNC and SDATA_IN samples
//   en                   deframer enable
//   next_frame           one-cycle pulse when a frame is published
//   frame_valid          published tag bit 15
//   slot_valid           published tag valid bits, bit i-1 = slot i
//   slot_data            published slot words, slot i at [i*SLOT_BITS-1 -: SLOT_BITS]
//   locked               set once a SYNC rising edge has been accepted
//   sync_err             (only with AC97_DEFRAMER_SYNCERR_EN) sticky frame-length error
//
// Optional feature macro: AC97_DEFRAMER_SYNCERR_EN

module ac97_deframer_ms #(
    parameter int NSLOTS    = 4,
    parameter int SLOT_BITS = 20
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        up_stb,
    output logic                        up_ack,
    input  logic                        up_sync,
    input  logic                        up_data,
    input  logic                        en,
    output logic                        next_frame,
    output logic                        frame_valid,
    output logic [NSLOTS-1:0]           slot_valid,
    output logic [NSLOTS*SLOT_BITS-1:0] slot_data,
`ifdef AC97_DEFRAMER_SYNCERR_EN
    output logic                        sync_err,
`endif
    output logic                        locked
);

    // Index of the final bit of the last decoded slot; accepting it publishes.
    localparam logic [7:0] LAST_BIT  = 8'(16 + 20 * NSLOTS - 1);
    localparam logic [7:0] CNT_RESET = 8'd253;
    localparam logic [7:0] CNT_MAX   = 8'd255;

    logic [7:0]                  cnt_q, cnt_d;
    logic                        prev_sync_q, prev_sync_d;
    logic                        locked_q, locked_d;
    // Set once the counter has consumed bit 255 without a new SYNC edge;
    // further bits at the held count must not be decoded again.
    logic                        sat_q, sat_d;

    logic                        fv_sh_q, fv_sh_d;
    logic [NSLOTS-1:0]           sv_sh_q, sv_sh_d;
    logic [NSLOTS*SLOT_BITS-1:0] sd_sh_q, sd_sh_d;

    logic                        next_frame_q, next_frame_d;
    logic                        fv_q, fv_d;
    logic [NSLOTS-1:0]           sv_q, sv_d;
    logic [NSLOTS*SLOT_BITS-1:0] sd_q, sd_d;

    logic                        accept;
    logic                        sync_rise;
    logic                        decode;
    logic                        publish;

`ifdef AC97_DEFRAMER_SYNCERR_EN
    logic                        sync_err_q, sync_err_d;
`endif

    assign up_ack = en;

    always_comb begin
        cnt_d        = cnt_q;
        prev_sync_d  = prev_sync_q;
        locked_d     = locked_q;
        sat_d        = sat_q;
        fv_sh_d      = fv_sh_q;
        sv_sh_d      = sv_sh_q;
        sd_sh_d      = sd_sh_q;
        fv_d         = fv_q;
        sv_d         = sv_q;
        sd_d         = sd_q;

        accept    = up_stb & en;
        sync_rise = accept & up_sync & ~prev_sync_q;
        // Decode uses the lock state from before this bit, so the bit that
        // first locks the link is itself ignored.
        decode    = accept & locked_q & ~sat_q;
        publish   = decode & (cnt_q == LAST_BIT);

`ifdef AC97_DEFRAMER_SYNCERR_EN
        sync_err_d = sync_err_q | (sync_rise & locked_q & (cnt_q != CNT_MAX));
`endif

        if (accept) begin
            prev_sync_d = up_sync;
            if (sync_rise) begin
                cnt_d    = 8'd0;
                locked_d = 1'b1;
                sat_d    = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        if (decode) begin
            if (cnt_q == 8'd0) begin
                fv_sh_d = up_data;
            end
            for (int i = 0; i < NSLOTS; i++) begin
                if (int'(cnt_q) == i + 1) begin
                    sv_sh_d[i] = up_data;
                end
                // Slots are 20 link bits wide; only the first SLOT_BITS are
                // shifted in, the remainder of the slot is dropped.
                if ((int'(cnt_q) >= 16 + 20 * i) &&
                    (int'(cnt_q) <  16 + 20 * i + SLOT_BITS)) begin
                    sd_sh_d[i*SLOT_BITS +: SLOT_BITS] =
                        {sd_sh_q[i*SLOT_BITS +: SLOT_BITS-1], up_data};
                end
            end
        end

        next_frame_d = publish;
        if (publish) begin
            fv_d = fv_sh_d;
            sv_d = sv_sh_d;
            sd_d = sd_sh_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q        <= CNT_RESET;
            prev_sync_q  <= 1'b0;
            locked_q     <= 1'b0;
            sat_q        <= 1'b0;
            fv_sh_q      <= 1'b0;
            sv_sh_q      <= '0;
            sd_sh_q      <= '0;
            next_frame_q <= 1'b0;
            fv_q         <= 1'b0;
            sv_q         <= '0;
            sd_q         <= '0;
`ifdef AC97_DEFRAMER_SYNCERR_EN
            sync_err_q   <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            prev_sync_q  <= prev_sync_d;
            locked_q     <= locked_d;
            sat_q        <= sat_d;
            fv_sh_q      <= fv_sh_d;
            sv_sh_q      <= sv_sh_d;
            sd_sh_q      <= sd_sh_d;
            next_frame_q <= next_frame_d;
            fv_q         <= fv_d;
            sv_q         <= sv_d;
            sd_q         <= sd_d;
`ifdef AC97_DEFRAMER_SYNCERR_EN
            sync_err_q   <= sync_err_d;
`endif
        end
    end

    assign next_frame  = next_frame_q;
    assign frame_valid = fv_q;
    assign slot_valid  = sv_q;
    assign slot_data   = sd_q;
    assign locked      = locked_q;
`ifdef AC97_DEFRAMER_SYNCERR_EN
    assign sync_err    = sync_err_q;
`endif

endmodule

// File: tb/tb_ac97_deframer_ms.sv
// tb/tb_ac97_deframer_ms.sv - scoreboard bench for ac97_deframer_ms (4x20 and 12x16 builds)

module tb_ac97_deframer_ms;

    typedef struct {
        int           cyc;
        logic         fv;
        logic [11:0]  sv;
        logic [239:0] sd;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    logic up_stb = 1'b0;
    logic up_sync = 1'b0;
    logic up_data = 1'b0;
    logic en = 1'b1;

    logic         ack_a, nf_a, fv_a, lk_a;
    logic [3:0]   sv_a;
    logic [79:0]  sd_a;
    logic         ack_b, nf_b, fv_b, lk_b;
    logic [11:0]  sv_b;
    logic [191:0] sd_b;
`ifdef AC97_DEFRAMER_SYNCERR_EN
    logic         se_a, se_b;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic rst_edge = 1'b1;
    bit   model_locked = 1'b0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t last_a;
    exp_t last_b;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= sys_rst;
    end

    ac97_deframer_ms dut_a (
        .sys_clk(clk), .sys_rst(sys_rst), .up_stb(up_stb), .up_ack(ack_a),
        .up_sync(up_sync), .up_data(up_data), .en(en), .next_frame(nf_a),
        .frame_valid(fv_a), .slot_valid(sv_a), .slot_data(sd_a),
`ifdef AC97_DEFRAMER_SYNCERR_EN
        .sync_err(se_a),
`endif
        .locked(lk_a)
    );

    ac97_deframer_ms #(.NSLOTS(12), .SLOT_BITS(16)) dut_b (
        .sys_clk(clk), .sys_rst(sys_rst), .up_stb(up_stb), .up_ack(ack_b),
        .up_sync(up_sync), .up_data(up_data), .en(en), .next_frame(nf_b),
        .frame_valid(fv_b), .slot_valid(sv_b), .slot_data(sd_b),
`ifdef AC97_DEFRAMER_SYNCERR_EN
        .sync_err(se_b),
`endif
        .locked(lk_b)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.cyc = 0; e.fv = 1'b0; e.sv = '0; e.sd = '0;
        return e;
    endfunction

    // Reference: tag bit 0 -> frame_valid, tag bits 1..ns -> slot_valid,
    // slot i = the first sb link bits of its 20-bit field, first bit is MSB.
    function automatic exp_t calc(input logic [255:0] fb, input int ns, input int sb);
        exp_t e;
        e = zero_exp();
        e.fv = fb[0];
        for (int i = 1; i <= ns; i++) begin
            e.sv[i-1] = fb[i];
            for (int b = 0; b < sb; b++)
                e.sd[(i-1)*sb + sb-1-b] = fb[16 + 20*(i-1) + b];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) last_a = zero_exp();
        if (nf_a === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_next_frame", nf_a, 0);
            end else begin
                e = qa.pop_front();
                chk("a_publish_cycle", cyc, e.cyc);
                chk("a_frame_valid", fv_a, e.fv);
                chk("a_slot_valid", sv_a, e.sv[3:0]);
                chk("a_slot_data", sd_a, e.sd[79:0]);
                last_a = e;
            end
        end else if (cyc % 64 == 0) begin
            chk("a_outputs_hold", {fv_a, sv_a, sd_a}, {last_a.fv, last_a.sv[3:0], last_a.sd[79:0]});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) last_b = zero_exp();
        if (nf_b === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_next_frame", nf_b, 0);
            end else begin
                e = qb.pop_front();
                chk("b_publish_cycle", cyc, e.cyc);
                chk("b_frame_valid", fv_b, e.fv);
                chk("b_slot_valid", sv_b, e.sv);
                chk("b_slot_data", sd_b, e.sd[191:0]);
                last_b = e;
            end
        end else if (cyc % 64 == 0) begin
            chk("b_outputs_hold", {fv_b, sv_b, sd_b}, {last_b.fv, last_b.sv, last_b.sd[191:0]});
        end
    end

    // Called right after a falling edge; the bit is accepted on the next rise.
    task automatic strobe(input logic s, input logic d);
        up_sync = s; up_data = d; up_stb = 1'b1;
        @(negedge clk);
        up_stb = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_gap();
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            up_stb  = (i % 4 == 0);
            up_data = 1'($urandom);
            up_sync = 1'($urandom);
            #1;
            chk("ack_low_while_disabled", {ack_a, ack_b}, 2'b00);
            @(negedge clk);
        end
        up_stb = 1'b0;
        en = 1'b1;
    endtask

    task automatic send_frame(input logic [255:0] fb, input int len, input int gap_at, input bit tail);
        exp_t ea, eb;
        ea = calc(fb, 4, 20);
        eb = calc(fb, 12, 16);
        for (int k = 0; k < len; k++) begin
            if (k == gap_at) do_gap();
            if (model_locked && k == 95)  begin ea.cyc = cyc + 1; qa.push_back(ea); end
            if (model_locked && k == 255) begin eb.cyc = cyc + 1; qb.push_back(eb); end
            strobe((k < 15) || (tail && k == len - 1), fb[k]);
        end
        if (tail) model_locked = 1'b1;
        chk("locked_after_frame", {lk_a, lk_b}, {2{model_locked}});
        chk("ack_high_enabled", {ack_a, ack_b}, 2'b11);
    endtask

    function automatic logic [255:0] rand_frame();
        logic [255:0] fb;
        for (int j = 0; j < 8; j++) fb[j*32 +: 32] = $urandom();
        return fb;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] fb;
        logic [19:0]  w [4];
        last_a = zero_exp();
        last_b = zero_exp();
        repeat (3) @(negedge clk);
        chk("reset_locked", {lk_a, lk_b}, 2'b00);
        chk("reset_next_frame", {nf_a, nf_b}, 2'b00);
        chk("reset_outputs", {fv_a, sv_a, sd_a, fv_b, sv_b, sd_b}, '0);
        sys_rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 300; i++) strobe(1'b0, 1'($urandom));
        chk("nosync_locked", {lk_a, lk_b}, 2'b00);
        chk("nosync_outputs", {fv_a, sv_a, sd_a, fv_b, sv_b, sd_b}, '0);

        strobe(1'b1, 1'b0);
        model_locked = 1'b1;
        chk("locked_after_first_edge", {lk_a, lk_b}, 2'b11);

        fb = rand_frame();
        fb[15:0] = 16'h001F;
        w[0] = 20'h12345; w[1] = 20'hABCDE; w[2] = 20'h00001; w[3] = 20'h80000;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 20; b++) fb[16 + 20*i + b] = w[i][19-b];
        send_frame(fb, 256, -1, 1'b1);
        chk("known_frame_slot_data", sd_a, {w[3], w[2], w[1], w[0]});
        chk("known_frame_valid_bits", {fv_a, sv_a}, 5'h1F);

        send_frame(rand_frame(), 256, 50, 1'b1);
        send_frame(rand_frame(), 61, -1, 1'b1);
`ifdef AC97_DEFRAMER_SYNCERR_EN
        chk("sync_err_after_short_frame", {se_a, se_b}, 2'b11);
`endif
        send_frame(rand_frame(), 256, -1, 1'b1);

        send_frame(rand_frame(), 40, -1, 1'b0);
        up_sync = 1'b1; up_data = 1'b1; up_stb = 1'b1; sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0; up_stb = 1'b0; up_sync = 1'b0;
        model_locked = 1'b0;
        chk("midframe_reset_locked", {lk_a, lk_b}, 2'b00);
        chk("midframe_reset_outputs", {fv_a, sv_a, sd_a, fv_b, sv_b, sd_b}, '0);
        repeat (3) @(negedge clk);

        strobe(1'b1, 1'b1);
        model_locked = 1'b1;
        send_frame(rand_frame(), 256, -1, 1'b1);
        send_frame(rand_frame(), 256, 200, 1'b1);

        repeat (8) @(negedge clk);
        chk("a_all_frames_published", qa.size(), 0);
        chk("b_all_frames_published", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
